// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO and runs mult/multu/div/divu
// with a fixed busy latency. It also services mthi/mtlo.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hilo_we,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      tmp_hi;
  logic [31:0]      tmp_lo;
  logic             tmp_ok;

  logic signed [63:0] a_s64;
  logic signed [63:0] b_s64;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] div_a;
  logic signed [31:0] div_b;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;
  logic        [63:0] res;

  // Full 64-bit result for the requested operation, computed from the current operands.
  // The divisor is forced to 1 on divide-by-zero and on the single signed overflow case
  // so the divider never sees an undefined operation; those cases are patched afterwards.
  always_comb begin
    a_s64    = {{32{A[31]}}, A};
    b_s64    = {{32{B[31]}}, B};
    prod_s   = a_s64 * b_s64;
    prod_u   = {32'd0, A} * {32'd0, B};
    div_zero = (B == 32'd0);
    div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    div_a    = $signed(A);
    div_b    = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
    quo_s    = div_a / div_b;
    rem_s    = div_a % div_b;
    quo_u    = A / (div_zero ? 32'd1 : B);
    rem_u    = A % (div_zero ? 32'd1 : B);
    case (md_op[1:0])
      2'd0:    res = prod_s;
      2'd1:    res = prod_u;
      2'd2:    res = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
      default: res = {rem_u, quo_u};
    endcase
  end

  // Control FSM: accepts starts and mthi/mtlo when idle, counts down the busy
  // period, and commits the latched result to HI/LO as busy falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      tmp_ok <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !req) begin
            if (md_op[2] == 1'b0) begin
              tmp_hi <= res[63:32];
              tmp_lo <= res[31:0];
              tmp_ok <= !(md_op[1] && div_zero);
              cnt    <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state  <= RUN;
              busy   <= 1'b1;
            end
          end else if (hilo_we && !req) begin
            if (md_op == 3'd4) HI <= A;
            else if (md_op == 3'd5) LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (tmp_ok) begin
              HI <= tmp_hi;
              LO <= tmp_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO results and busy lengths.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        hilo_we;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .hilo_we(hilo_we), .md_op(md_op),
    .A(A), .B(B), .req(req), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    step();
    start = 1'b0;
  endtask

  task automatic hilo_write(input logic [2:0] op, input logic [31:0] a);
    hilo_we = 1'b1; md_op = op; A = a;
    step();
    hilo_we = 1'b0;
  endtask

  // Counts busy cycles starting from 'seen' already observed; bounded wait.
  task automatic finish_op(input string tag, input int seen, input int exp_n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int k;
    k = seen;
    while (busy && k < 64) begin
      k++;
      step();
    end
    check({tag, "_busy_cycles"}, k, exp_n);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hilo_we = 1'b0; md_op = 3'd0;
    A = 32'd0; B = 32'd0; req = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_hi", HI, 0);
    check("reset_lo", LO, 0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy_first", busy, 1);
    finish_op("mult_neg", 0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    finish_op("multu", 0, 5, 32'h0000_0001, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", 0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    finish_op("div_negdiv", 0, 10, 32'h0000_0001, 32'hFFFF_FFFD);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 0, 10, 32'h0000_0000, 32'h8000_0000);

    hilo_write(3'd4, 32'h11);
    hilo_write(3'd5, 32'h22);
    check("mthi_11", HI, 32'h11);
    check("mtlo_22", LO, 32'h22);
    issue(3'd3, 32'd100, 32'd0);
    finish_op("divu_zero", 0, 10, 32'h11, 32'h22);

    hilo_write(3'd4, 32'h1234);
    check("mthi_hi", HI, 32'h1234);
    check("mthi_busy", busy, 0);

    issue(3'd0, 32'd6, 32'd7);
    step();
    hilo_we = 1'b1; md_op = 3'd5; A = 32'hDEAD;
    step();
    hilo_we = 1'b0;
    finish_op("mtlo_blocked", 2, 5, 32'h0, 32'd42);

    start = 1'b1; req = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd4;
    step();
    start = 1'b0; req = 1'b0;
    check("req_start_busy", busy, 0);
    check("req_start_hi", HI, 32'h0);
    check("req_start_lo", LO, 32'd42);

    start = 1'b1; hilo_we = 1'b1; md_op = 3'd6; A = 32'h5555; B = 32'd9;
    step();
    start = 1'b0;
    md_op = 3'd7;
    step();
    hilo_we = 1'b0;
    check("rsvd_busy", busy, 0);
    check("rsvd_hi", HI, 32'h0);
    check("rsvd_lo", LO, 32'd42);

    issue(3'd0, 32'd3, 32'd4);
    step();
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    finish_op("req_inflight", 3, 5, 32'h0, 32'd12);

    issue(3'd2, 32'd100, 32'd7);
    step(); step(); step();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    for (int i = 0; i < 15; i++) step();
    check("abort_nocommit_hi", HI, 32'h0);
    check("abort_nocommit_lo", LO, 32'h0);
    check("abort_nocommit_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
